// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants, state encoding and helpers
// for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

  localparam int BCD_NIBBLE_W   = 4;
  localparam int BCD_ADJ_THRESH = 5;
  localparam int BCD_ADJ_ADD    = 3;

  typedef logic [0:0] state_t;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between the value source
// and the converter feeding the display stage.
interface bin_to_bcd_seq_if #(
  parameter int IN_WIDTH = 14,
  parameter int DIGITS   = 4
);

  logic                  start;
  logic [IN_WIDTH-1:0]   bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd,
    input  overflow
  );

  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd,
    output overflow
  );

endinterface

// File: rtl/bin_to_bcd_seq_digit_adjust.sv
// One BCD nibble of the double-dabble step:
// add 3 when the digit is 5 or more.
module bcd_digit_adjust
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_NIBBLE_W-1:0] i_nib,
  output logic [BCD_NIBBLE_W-1:0] o_nib
);

  logic w_ge;

  assign w_ge  = (i_nib >= BCD_NIBBLE_W'(BCD_ADJ_THRESH));
  assign o_nib = w_ge ? i_nib + BCD_NIBBLE_W'(BCD_ADJ_ADD)
                      : i_nib;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Shift-and-add-3 binary-to-BCD converter, one bit
// per clock; result held between conversions.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int IN_WIDTH = 14,
  parameter int DIGITS   = 4
) (
  input  logic clk,
  input  logic rst_n,
  bin_to_bcd_seq_if.slave bus
);

  localparam int          CW    = $clog2(IN_WIDTH + 1);
  localparam int          BW    = BCD_NIBBLE_W * DIGITS;
  localparam logic [31:0] LIMIT = 32'(pow10(DIGITS) - 1);
  localparam logic [BW-1:0] SAT = {DIGITS{4'h9}};

  state_t              r_state;
  logic [IN_WIDTH-1:0] r_shreg;
  logic [BW-1:0]       r_scr;
  logic [CW-1:0]       r_cnt;
  logic                r_ovf;
  logic                r_done;
  logic [BW-1:0]       r_bcd;
  logic                r_overflow;

  logic [BW-1:0]       w_adj;
  logic [BW-1:0]       w_scr_nxt;
  logic [IN_WIDTH-1:0] w_sh_nxt;
  logic                w_ovf_in;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
        .i_nib (r_scr[g*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
        .o_nib (w_adj[g*BCD_NIBBLE_W +: BCD_NIBBLE_W])
      );
    end
  endgenerate

  assign {w_scr_nxt, w_sh_nxt} = {w_adj, r_shreg} << 1;
  assign w_ovf_in = (32'(bus.bin) > LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_shreg    <= '0;
      r_scr      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (1'b1)
        (r_state == ST_IDLE): begin
          if (bus.start) begin
            r_shreg <= bus.bin;
            r_scr   <= '0;
            r_cnt   <= CW'(IN_WIDTH);
            r_ovf   <= w_ovf_in;
            r_state <= ST_SHIFT;
          end
        end
        (r_state == ST_SHIFT): begin
          r_scr   <= w_scr_nxt;
          r_shreg <= w_sh_nxt;
          r_cnt   <= r_cnt - CW'(1);
          // last shift: publish the freshly shifted value directly
          if (r_cnt == CW'(1)) begin
            r_state    <= ST_IDLE;
            r_done     <= 1'b1;
            r_bcd      <= r_ovf ? SAT : w_scr_nxt;
            r_overflow <= r_ovf;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = (r_state == ST_SHIFT);
  assign bus.done     = r_done;
  assign bus.bcd      = r_bcd;
  assign bus.overflow = r_overflow;

endmodule
